// File: rtl/fpu_req_arbiter.sv
// fpu_req_arbiter: round-robin share of one multi-cycle FPU core with watchdog and sticky exception flags.
module fpu_req_arbiter #(
    parameter int NEXP = 8,
    parameter int NSIG = 7,
    parameter int NREQ = 4,
    parameter int TIMEOUT = 64,
    localparam int W = 1 + NEXP + NSIG,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [2*NREQ-1:0]   req_op,
    input  logic [W*NREQ-1:0]   req_a,
    input  logic [W*NREQ-1:0]   req_b,
    output logic                fu_start,
    output logic                fu_abort,
    output logic [1:0]          fu_op,
    output logic [W-1:0]        fu_a,
    output logic [W-1:0]        fu_b,
    input  logic                fu_done,
    input  logic [W-1:0]        fu_result,
    input  logic [4:0]          fu_flags,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [W-1:0]        rsp_result,
    output logic [4:0]          rsp_flags,
    input  logic                sticky_clr,
    output logic [4:0]          sticky_flags,
    output logic                busy
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [W-1:0] QNAN = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           r_state, w_next;
    logic [IDW-1:0]   r_ptr, r_id, w_gnt_id, w_idx;
    logic             w_gnt_any, w_last, w_hs;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_op;
    logic [W-1:0]     r_a, r_b, r_res;
    logic [4:0]       r_fl, r_sticky;

    // Scan downward so the lowest offset from r_ptr wins.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_id = '0;
        w_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = IDW'((int'(r_ptr) + k) % NREQ);
            if (req_valid[w_idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_id = w_idx;
            end
        end
    end

    assign w_last = r_cnt == CW'(TIMEOUT - 1);
    assign w_hs = rsp_valid & rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        req_ready = '0;
        fu_start = 1'b0;
        fu_abort = 1'b0;
        unique case (r_state)
            IDLE: begin
                req_ready[w_gnt_id] = w_gnt_any;
                w_next = w_gnt_any ? ISSUE : IDLE;
            end
            ISSUE: begin
                fu_start = 1'b1;
                w_next = WAIT;
            end
            WAIT: begin
                fu_abort = ~fu_done & w_last;
                w_next = (fu_done | w_last) ? RESP : WAIT;
            end
            RESP: w_next = rsp_ready ? IDLE : RESP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_id <= '0;
            r_op <= '0;
            r_a <= '0;
            r_b <= '0;
            r_cnt <= '0;
            r_res <= '0;
            r_fl <= '0;
            r_sticky <= '0;
        end else begin
            if (r_state == IDLE && w_gnt_any) begin
                r_ptr <= IDW'((int'(w_gnt_id) + 1) % NREQ);
                r_id <= w_gnt_id;
                r_op <= req_op[2*w_gnt_id +: 2];
                r_a <= req_a[W*w_gnt_id +: W];
                r_b <= req_b[W*w_gnt_id +: W];
            end
            r_cnt <= r_state == ISSUE ? '0 : r_state == WAIT ? r_cnt + CW'(1) : r_cnt;
            if (r_state == WAIT && (fu_done || w_last)) begin
                r_res <= fu_done ? fu_result : QNAN;
                r_fl <= fu_done ? fu_flags : 5'b00001;
            end
            // A clear coinciding with a handshake wipes the old flags before merging.
            if (w_hs) r_sticky <= (sticky_clr ? 5'b0 : r_sticky) | r_fl;
            else if (sticky_clr) r_sticky <= '0;
        end
    end

    assign fu_op = r_op;
    assign fu_a = r_a;
    assign fu_b = r_b;
    assign rsp_valid = r_state == RESP;
    assign rsp_id = r_id;
    assign rsp_result = r_res;
    assign rsp_flags = r_fl;
    assign sticky_flags = r_sticky;
    assign busy = r_state != IDLE;
endmodule
